// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects and load-use stall detection from a shadow pipeline.
module fwd_hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);
    logic              ex_v_q, ex_rw_q, ex_mr_q, mem_v_q, mem_rw_q, mem_mr_q, wb_v_q, wb_rw_q;
    logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q, mem_rd_q, wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              ex_v_d, mem_wr, wb_wr;

    assign ex_v_d = id_valid_i & ~flush_i & ~stall_o;
    assign mem_wr = mem_v_q & mem_rw_q & (mem_rd_q != '0);
    assign wb_wr  = wb_v_q & wb_rw_q & (wb_rd_q != '0);

    // EX/MEM beats MEM/WB so the newest write wins
    always_comb begin
        fwd_a_o = !ex_v_q ? 2'b00 : (mem_wr && mem_rd_q == ex_rs_q) ? 2'b10 :
                  (wb_wr && wb_rd_q == ex_rs_q) ? 2'b01 : 2'b00;
        fwd_b_o = !ex_v_q ? 2'b00 : (mem_wr && mem_rd_q == ex_rt_q) ? 2'b10 :
                  (wb_wr && wb_rd_q == ex_rt_q) ? 2'b01 : 2'b00;
        stall_o = ex_v_q & ex_mr_q & (ex_rd_q != '0) & id_valid_i & ~flush_i &
                  (ex_rd_q == id_rs_i || ex_rd_q == id_rt_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_v_q      <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            mem_v_q     <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            mem_rd_q    <= '0;
            wb_v_q      <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
        end else if (!freeze_i) begin
            wb_v_q      <= mem_v_q;
            wb_rw_q     <= mem_rw_q;
            wb_rd_q     <= mem_rd_q;
            mem_v_q     <= ex_v_q;
            mem_rw_q    <= ex_rw_q;
            mem_mr_q    <= ex_mr_q;
            mem_rd_q    <= ex_rd_q;
            ex_v_q      <= ex_v_d;
            ex_rw_q     <= ex_v_d & id_regwrite_i;
            ex_mr_q     <= ex_v_d & id_memread_i;
            ex_rs_q     <= id_rs_i;
            ex_rt_q     <= id_rt_i;
            ex_rd_q     <= id_rd_i;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_o & ~&stall_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
endmodule
